boundary_scan_chain: RTL and testbench

BOUNDARY_SCAN_CHAIN -- requirements
Module: boundary_scan_chain

---
 rtl/boundary_scan_chain.sv | 76 +++++++
 tb/tb_boundary_scan_chain.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/boundary_scan_chain.sv
// Boundary-scan register: capture/shift/update cells between pads and core.
// Optional BSR_CLAMP_EN adds a clamp port that holds pins from upd and routes TDI through a 1-bit bypass.
module boundary_scan_chain #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter logic [N_IN+N_OUT-1:0] SAFE_VAL = '0
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             bsr_tdi,
  output logic             bsr_tdo,
  input  logic             shift_dr,
  input  logic             capture_dr,
  input  logic             update_dr,
  input  logic             extest,
`ifdef BSR_CLAMP_EN
  input  logic             clamp,
`endif
  input  logic [N_IN-1:0]  pad_in,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [N_OUT-1:0] pad_out,
  output logic [15:0]      shift_cnt
);

  localparam int L = N_IN + N_OUT;

  logic [L-1:0] sr;
  logic [L-1:0] upd;
  logic         clamp_act;
  logic         drive_pins;

`ifdef BSR_CLAMP_EN
  logic bypass;

  assign clamp_act = clamp;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      bypass <= 1'b0;
    end else if (capture_dr) begin
      bypass <= 1'b0;
    end else if (shift_dr) begin
      bypass <= bsr_tdi;
    end
  end

  assign bsr_tdo = clamp_act ? bypass : sr[0];
`else
  assign clamp_act = 1'b0;
  assign bsr_tdo   = sr[0];
`endif

  // Capture takes priority over shift; update always samples the pre-edge sr.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      sr        <= '0;
      upd       <= SAFE_VAL;
      shift_cnt <= '0;
    end else begin
      if (capture_dr) begin
        if (!clamp_act) sr <= {core_out, pad_in};
        shift_cnt <= '0;
      end else if (shift_dr) begin
        if (!clamp_act) sr <= {bsr_tdi, sr[L-1:1]};
        if (shift_cnt != 16'hFFFF) shift_cnt <= shift_cnt + 16'd1;
      end
      if (update_dr && !clamp_act) upd <= sr;
    end
  end

  assign drive_pins = extest | clamp_act;
  assign pad_out    = drive_pins ? upd[L-1:N_IN] : core_out;
  assign core_in    = drive_pins ? upd[N_IN-1:0] : pad_in;

endmodule

// File: tb/tb_boundary_scan_chain.sv
// Directed + randomized bench for boundary_scan_chain against a queue-based chain model.
module tb_boundary_scan_chain;

  localparam logic [7:0] SAFE = 8'hA5;

  logic       tck = 1'b0;
  logic       trst;
  logic       bsr_tdi;
  logic       bsr_tdo;
  logic       shift_dr;
  logic       capture_dr;
  logic       update_dr;
  logic       extest;
  logic [3:0] pad_in;
  logic [3:0] core_in;
  logic [3:0] core_out;
  logic [3:0] pad_out;
  logic [15:0] shift_cnt;
`ifdef BSR_CLAMP_EN
  logic       clamp = 1'b0;
`endif

  boundary_scan_chain #(.N_IN(4), .N_OUT(4), .SAFE_VAL(SAFE)) dut (
    .tck(tck), .trst(trst), .bsr_tdi(bsr_tdi), .bsr_tdo(bsr_tdo),
    .shift_dr(shift_dr), .capture_dr(capture_dr), .update_dr(update_dr),
    .extest(extest),
`ifdef BSR_CLAMP_EN
    .clamp(clamp),
`endif
    .pad_in(pad_in), .core_in(core_in), .core_out(core_out),
    .pad_out(pad_out), .shift_cnt(shift_cnt)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int failures = 0;

  // Chain model: q[0] is the cell nearest TDO; a shift pops the front and appends TDI.
  bit         q[$];
  logic [7:0] upd_m;
  int         cnt_m;

  function automatic logic [7:0] q_val();
    logic [7:0] v;
    v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    q = {};
    repeat (8) q.push_back(1'b0);
    upd_m = SAFE;
    cnt_m = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("bsr_tdo", {31'd0, bsr_tdo}, {31'd0, q[0]});
    check("shift_cnt", {16'd0, shift_cnt}, cnt_m);
    check("pad_out", {28'd0, pad_out}, {28'd0, extest ? upd_m[7:4] : core_out});
    check("core_in", {28'd0, core_in}, {28'd0, extest ? upd_m[3:0] : pad_in});
  endtask

  task automatic tick();
    logic [7:0] old;
    logic [7:0] cap;
    @(posedge tck);
    old = q_val();
    cap = {core_out, pad_in};
    if (capture_dr) begin
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(cap[i]);
      cnt_m = 0;
    end else if (shift_dr) begin
      void'(q.pop_front());
      q.push_back(bsr_tdi);
      if (cnt_m < 65535) cnt_m++;
    end
    if (update_dr) upd_m = old;
    #1;
    check_outputs();
  endtask

  task automatic pulse_reset();
    #2 trst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1 trst = 1'b0;
  endtask

  logic [7:0] pat;
  logic [7:0] val;

  initial begin
    trst = 1'b1; bsr_tdi = 1'b0; shift_dr = 1'b0; capture_dr = 1'b0;
    update_dr = 1'b0; extest = 1'b1; pad_in = 4'h0; core_out = 4'h0;
    #2;
    model_reset();
    check_outputs();
    check("rst_pad_out", {28'd0, pad_out}, 32'hA);
    check("rst_core_in", {28'd0, core_in}, 32'h5);
    check("rst_tdo", {31'd0, bsr_tdo}, 32'd0);
    check("rst_cnt", {16'd0, shift_cnt}, 32'd0);
    @(negedge tck);
    trst = 1'b0;

    // Sample C3 and shift it out.
    extest = 1'b0; pad_in = 4'h3; core_out = 4'hC; capture_dr = 1'b1;
    tick();
    pat = 8'b1100_0011;
    check("sample_bit0", {31'd0, bsr_tdo}, {31'd0, pat[0]});
    capture_dr = 1'b0; shift_dr = 1'b1;
    for (int k = 1; k < 8; k++) begin
      tick();
      check("sample_bit", {31'd0, bsr_tdo}, {31'd0, pat[k]});
    end
    tick();
    check("sample_cnt8", {16'd0, shift_cnt}, 32'd8);

    // Preload 96 and drive pins.
    val = 8'h96;
    for (int i = 0; i < 8; i++) begin
      bsr_tdi = val[i];
      tick();
    end
    shift_dr = 1'b0; update_dr = 1'b1;
    tick();
    update_dr = 1'b0; extest = 1'b1;
    #1;
    check("preload_pad_out", {28'd0, pad_out}, 32'h9);
    check("preload_core_in", {28'd0, core_in}, 32'h6);

    // All three enables on one edge.
    pad_in = 4'h1; core_out = 4'h7;
    capture_dr = 1'b1; shift_dr = 1'b1; update_dr = 1'b1;
    tick();
    check("simul_pad_out", {28'd0, pad_out}, 32'h9);
    check("simul_core_in", {28'd0, core_in}, 32'h6);
    check("simul_cnt", {16'd0, shift_cnt}, 32'd0);
    check("simul_tdo", {31'd0, bsr_tdo}, 32'd1);
    capture_dr = 1'b0; update_dr = 1'b0; bsr_tdi = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Reset in the middle of a shift sequence.
    for (int i = 0; i < 3; i++) begin
      bsr_tdi = 1'($urandom);
      tick();
    end
    pulse_reset();
    check("midrst_upd", {28'd0, core_in}, 32'h5);
    shift_dr = 1'b0; capture_dr = 1'b1; pad_in = 4'hA; core_out = 4'h5;
    tick();
    capture_dr = 1'b0; shift_dr = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Randomized traffic with occasional asynchronous reset.
    for (int n = 0; n < 400; n++) begin
      capture_dr = ($urandom_range(0, 7) == 0);
      shift_dr   = ($urandom_range(0, 1) == 1);
      update_dr  = ($urandom_range(0, 5) == 0);
      extest     = 1'($urandom);
      bsr_tdi    = 1'($urandom);
      pad_in     = 4'($urandom);
      core_out   = 4'($urandom);
      tick();
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    // Counter saturation.
    capture_dr = 1'b0; update_dr = 1'b0; shift_dr = 1'b1; bsr_tdi = 1'b0;
    repeat (70000) @(posedge tck);
    q = {};
    repeat (8) q.push_back(1'b0);
    cnt_m = 65535;
    #1;
    check_outputs();
    check("sat_cnt", {16'd0, shift_cnt}, 32'hFFFF);
    tick();

`ifdef BSR_CLAMP_EN
    extest = 1'b0; clamp = 1'b1; bsr_tdi = 1'b1; shift_dr = 1'b1; update_dr = 1'b1;
    @(posedge tck);
    #1;
    check("clamp_tdo", {31'd0, bsr_tdo}, 32'd1);
    check("clamp_pad_out", {28'd0, pad_out}, {28'd0, upd_m[7:4]});
    check("clamp_core_in", {28'd0, core_in}, {28'd0, upd_m[3:0]});
    check("clamp_cnt", {16'd0, shift_cnt}, 32'hFFFF);
    clamp = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    #1;
    check_outputs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
